// File: rtl/car_power_ctrl.sv
// Power-state sequencer: turns qualified power-button presses and idle timeouts
// into OFF -> STARTUP -> ON -> SHUTDOWN -> OFF transitions with registered outputs.
module car_power_ctrl #(
    parameter int STARTUP_CYC  = 8,
    parameter int SHUTDOWN_CYC = 8,
    parameter int IDLE_CYC     = 64,
    parameter int BLINK_HALF   = 4,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on,
    input  logic       activity,
    output logic       sys_en,
    output logic       drive_en,
    output logic       led,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_OFF      = 2'b00,
        S_STARTUP  = 2'b01,
        S_ON       = 2'b10,
        S_SHUTDOWN = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] STARTUP_LAST  = CNT_W'(STARTUP_CYC - 1);
    localparam logic [CNT_W-1:0] SHUTDOWN_LAST = CNT_W'(SHUTDOWN_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST     = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST    = CNT_W'(BLINK_HALF - 1);

    state_t           r_state;
    logic             r_pwr_q;
    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] r_idle;
    logic [CNT_W-1:0] r_blink;
    logic             r_sys_en;
    logic             r_drive_en;
    logic             r_led;

    state_t           w_next_state;
    logic             w_press;
    logic             w_timeout;
    logic             w_entry;
    logic [CNT_W-1:0] w_phase_nxt;
    logic [CNT_W-1:0] w_idle_nxt;
    logic [CNT_W-1:0] w_blink_nxt;
    logic             w_led_nxt;

    assign w_press   = power_on & ~r_pwr_q;
    assign w_timeout = (r_state == S_ON) && !activity && (r_idle == IDLE_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_OFF: begin
                if (w_press) w_next_state = S_STARTUP;
            end
            S_STARTUP: begin
                // abort wins over completion
                if (w_press)                      w_next_state = S_SHUTDOWN;
                else if (r_phase == STARTUP_LAST) w_next_state = S_ON;
            end
            S_ON: begin
                if (w_press || w_timeout) w_next_state = S_SHUTDOWN;
            end
            S_SHUTDOWN: begin
                if (r_phase == SHUTDOWN_LAST) w_next_state = S_OFF;
            end
            default: w_next_state = S_OFF;
        endcase
    end

    assign w_entry = (w_next_state != r_state);

    always_comb begin
        w_phase_nxt = '0;
        w_idle_nxt  = '0;
        w_blink_nxt = '0;
        w_led_nxt   = 1'b0;
        if (!w_entry && (w_next_state == S_STARTUP || w_next_state == S_SHUTDOWN))
            w_phase_nxt = r_phase + 1'b1;
        if (!w_entry && w_next_state == S_ON && !activity)
            w_idle_nxt = r_idle + 1'b1;
        case (w_next_state)
            S_STARTUP, S_SHUTDOWN: begin
                // blink restarts lit on every entry, then toggles each half period
                if (w_entry) begin
                    w_led_nxt = 1'b1;
                end else if (r_blink == BLINK_LAST) begin
                    w_led_nxt = ~r_led;
                end else begin
                    w_blink_nxt = r_blink + 1'b1;
                    w_led_nxt   = r_led;
                end
            end
            S_ON:    w_led_nxt = 1'b1;
            default: w_led_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_OFF;
            r_pwr_q    <= 1'b1;
            r_phase    <= '0;
            r_idle     <= '0;
            r_blink    <= '0;
            r_sys_en   <= 1'b0;
            r_drive_en <= 1'b0;
            r_led      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pwr_q    <= power_on;
            r_phase    <= w_phase_nxt;
            r_idle     <= w_idle_nxt;
            r_blink    <= w_blink_nxt;
            r_sys_en   <= (w_next_state != S_OFF);
            r_drive_en <= (w_next_state == S_ON);
            r_led      <= w_led_nxt;
        end
    end

    assign state    = r_state;
    assign sys_en   = r_sys_en;
    assign drive_en = r_drive_en;
    assign led      = r_led;

endmodule
